// File: rtl/gate_truth_table_checker.sv
// Truth-table self-test sequencer for the two-input logic-gate block.
// Ports: clk, rst_n, start in; A, B drive the gate block; gate_in (8) samples it;
//        busy, done, pass, fail_mask (8), fail_vec (4) report the last run.
module gate_truth_table_checker #(
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       A,
  output logic       B,
  input  logic [7:0] gate_in,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] fail_mask,
  output logic [3:0] fail_vec
);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    DONE
  } state_t;

  localparam logic [CNT_W-1:0] RELOAD =
    CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_t           state;
  state_t           state_d;
  logic [1:0]       idx;
  logic [1:0]       idx_d;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_d;

  logic       a_d;
  logic       b_d;
  logic       busy_d;
  logic       done_d;
  logic       pass_d;
  logic [7:0] mask_d;
  logic [3:0] vec_d;

  logic [7:0] golden;
  logic [7:0] mism;
  logic [3:0] vec_upd;
  logic [1:0] idx_inc;

  // Expected gate_in per {A,B}; bit order is
  // Xnor Xor Nor Or Nand And Not Buf (MSB..LSB).
  always_comb begin
    golden = 8'hAA;
    unique case (idx)
      2'd0: golden = 8'hAA;
      2'd1: golden = 8'h5A;
      2'd2: golden = 8'h59;
      2'd3: golden = 8'h95;
      default: golden = 8'hAA;
    endcase
  end

  assign mism    = gate_in ^ golden;
  assign idx_inc = idx + 2'd1;

  // Result vector including the sample taken this cycle,
  // so pass can reflect the final vector on DONE entry.
  always_comb begin
    vec_upd      = fail_vec;
    vec_upd[idx] = |mism;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state;
    unique case (state)
      IDLE: begin
        if (start) state_d = SETTLE;
      end
      SETTLE: begin
        if (cnt == '0) state_d = SAMPLE;
      end
      SAMPLE: begin
        if (idx == 2'd3) state_d = DONE;
        else             state_d = SETTLE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath next values; everything
  // below is registered, so DONE outputs are
  // prepared on the final SAMPLE cycle.
  always_comb begin
    a_d    = A;
    b_d    = B;
    idx_d  = idx;
    cnt_d  = cnt;
    busy_d = busy;
    done_d = 1'b0;
    pass_d = pass;
    mask_d = fail_mask;
    vec_d  = fail_vec;
    unique case (state)
      IDLE: begin
        if (start) begin
          a_d    = 1'b0;
          b_d    = 1'b0;
          idx_d  = 2'd0;
          cnt_d  = RELOAD;
          mask_d = 8'h00;
          vec_d  = 4'h0;
          pass_d = 1'b0;
          busy_d = 1'b1;
        end
      end
      SETTLE: begin
        if (cnt != '0) cnt_d = cnt - ONE;
      end
      SAMPLE: begin
        mask_d = fail_mask | mism;
        vec_d  = vec_upd;
        if (idx == 2'd3) begin
          done_d = 1'b1;
          busy_d = 1'b0;
          pass_d = (vec_upd == 4'h0);
        end else begin
          idx_d      = idx_inc;
          {a_d, b_d} = idx_inc;
          cnt_d      = RELOAD;
        end
      end
      DONE: begin
        busy_d = 1'b0;
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  // Datapath / output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      A         <= 1'b0;
      B         <= 1'b0;
      idx       <= 2'd0;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail_mask <= 8'h00;
      fail_vec  <= 4'h0;
    end else begin
      A         <= a_d;
      B         <= b_d;
      idx       <= idx_d;
      cnt       <= cnt_d;
      busy      <= busy_d;
      done      <= done_d;
      pass      <= pass_d;
      fail_mask <= mask_d;
      fail_vec  <= vec_d;
    end
  end

endmodule

// File: tb/tb_gate_truth_table_checker.sv
// Directed bench for gate_truth_table_checker.
// Two instances: default settle (2) and settle 1.
module tb_gate_truth_table_checker;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic st = 1'b0;
  int   sel = 0;
  int   fmode = 0;

  logic       a0, b0, busy0, done0, pass0;
  logic [7:0] g0, mask0;
  logic [3:0] vec0;
  logic       a1, b1, busy1, done1, pass1;
  logic [7:0] g1, mask1;
  logic [3:0] vec1;
  logic       start0, start1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign start0 = st && (sel == 0);
  assign start1 = st && (sel == 1);

  gate_truth_table_checker #(
    .SETTLE_CYCLES(2), .CNT_W(4)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0),
    .A(a0), .B(b0), .gate_in(g0),
    .busy(busy0), .done(done0), .pass(pass0),
    .fail_mask(mask0), .fail_vec(vec0)
  );

  gate_truth_table_checker #(
    .SETTLE_CYCLES(1), .CNT_W(4)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1),
    .A(a1), .B(b1), .gate_in(g1),
    .busy(busy1), .done(done1), .pass(pass1),
    .fail_mask(mask1), .fail_vec(vec1)
  );

  // Gate block model with optional faults:
  // 1 = And stuck at 0, 2 = Xor/Xnor swapped.
  function automatic logic [7:0] gm(
    input logic a, input logic b, input int m);
    logic [7:0] g;
    g = {~(a ^ b), a ^ b, ~(a | b), a | b,
         ~(a & b), a & b, ~a, a};
    if (m == 1) g[2] = 1'b0;
    if (m == 2) g = {g[6], g[7], g[5:0]};
    return g;
  endfunction

  assign g0 = gm(a0, b0, fmode);
  assign g1 = gm(a1, b1, fmode);

  logic       a_s, b_s, busy_s, done_s, pass_s;
  logic [7:0] mask_s;
  logic [3:0] vec_s;
  assign a_s    = sel == 1 ? a1 : a0;
  assign b_s    = sel == 1 ? b1 : b0;
  assign busy_s = sel == 1 ? busy1 : busy0;
  assign done_s = sel == 1 ? done1 : done0;
  assign pass_s = sel == 1 ? pass1 : pass0;
  assign mask_s = sel == 1 ? mask1 : mask0;
  assign vec_s  = sel == 1 ? vec1 : vec0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    string      tag;
    int         mode;
    bit         repulse;
    logic       pass;
    logic [7:0] mask;
    logic [3:0] vec;
  } vec_t;

  // Full run on the selected instance. Edge 0 is
  // the edge that samples start.
  task automatic run(input vec_t v);
    int n;
    n = (sel == 1) ? 2 : 3;
    fmode = v.mode;
    st = 1'b1;
    step();
    st = 1'b0;
    chk({v.tag, " busy_on"}, busy_s, 1);
    chk({v.tag, " clr_pass"}, pass_s, 0);
    chk({v.tag, " clr_mask"}, mask_s, 0);
    chk({v.tag, " clr_vec"}, vec_s, 0);
    for (int e = 0; e <= 4 * n + 1; e++) begin
      if (e > 0) step();
      if (e < 4 * n)
        chk($sformatf("%s ab@%0d", v.tag, e),
            {a_s, b_s}, e / n);
      chk($sformatf("%s done@%0d", v.tag, e),
          done_s, (e == 4 * n) ? 1 : 0);
      if (e == 4 * n)
        chk({v.tag, " busy_done"}, busy_s, 0);
      st = v.repulse && (e == 3 || e == 7);
    end
    st = 1'b0;
    chk({v.tag, " pass"}, pass_s, v.pass);
    chk({v.tag, " mask"}, mask_s, v.mask);
    chk({v.tag, " vec"}, vec_s, v.vec);
    chk({v.tag, " busy_off"}, busy_s, 0);
  endtask

  vec_t tbl[4];

  initial begin
    tbl[0] = '{"clean", 0, 0, 1, 8'h00, 4'h0};
    tbl[1] = '{"and0",  1, 0, 0, 8'h04, 4'b1000};
    tbl[2] = '{"swap",  2, 0, 0, 8'hC0, 4'hF};
    tbl[3] = '{"repls", 0, 1, 1, 8'h00, 4'h0};

    rst_n = 1'b0;
    step();
    step();
    chk("rst_ab", {a0, b0}, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_done", done0, 0);
    chk("rst_pass", pass0, 0);
    chk("rst_mask", mask0, 0);
    chk("rst_vec", vec0, 0);
    rst_n = 1'b1;
    step();

    sel = 0;
    for (int i = 0; i < 4; i++) begin
      run(tbl[i]);
      step();
    end

    // Idle hold: previous result persists
    step();
    chk("hold_pass", pass0, 1);
    chk("hold_done", done0, 0);

    // Reset during vector 10 settle, with the
    // swap fault so there are results to clear.
    fmode = 2;
    st = 1'b1;
    step();
    st = 1'b0;
    for (int e = 1; e <= 7; e++) step();
    chk("pre_ab", {a0, b0}, 2'b10);
    chk("pre_mask", mask0, 8'hC0);
    chk("pre_busy", busy0, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_ab", {a0, b0}, 0);
    chk("ar_busy", busy0, 0);
    chk("ar_mask", mask0, 0);
    chk("ar_vec", vec0, 0);
    chk("ar_pass", pass0, 0);
    step();
    chk("ar_done", done0, 0);
    rst_n = 1'b1;
    for (int e = 0; e < 8; e++) begin
      step();
      chk("ar_nodone", done0, 0);
      chk("ar_idle", busy0, 0);
    end
    run(tbl[0]);
    step();

    // Settle-1 instance, back-to-back runs:
    // the second start lands the cycle after done.
    sel = 1;
    run(tbl[0]);
    run(tbl[0]);
    run(tbl[2]);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: run did not complete");
    $fatal(1, "timeout");
  end

endmodule
